// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch stage sitting directly in front of the ALU. It holds a 32x32
// register file (R0 hard-wired to zero) and a one-deep output register that
// presents input1/input2/ALUControl to the ALU.
//
// Operand A is R[rs]. Operand B is either R[rt] or the 16-bit immediate,
// sign- or zero-extended. The operation is captured under a valid/ready
// handshake. There is no skid buffer: in_ready = !out_valid || out_ready.
//
// The write-back port is independent of the handshake. It writes on every
// clock edge where wb_en=1, including while the stage is stalled.
//
// Optional feature: define ALU_OPERAND_BYPASS_EN to add write-through on
// reads. A read whose index matches a nonzero wb_addr while wb_en=1 returns
// wb_data in the same cycle. Without the macro, the read returns the value
// already in the array. In that case decode must insert one bubble on a
// read-after-write hazard.
//
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   in_valid     in   1       decode presents an operation
//   in_ready     out  1       stage can accept the operation this cycle
//   rs_addr      in   5       operand A register index
//   rt_addr      in   5       operand B register index
//   imm          in   16      immediate field
//   use_imm      in   1       1: operand B = extended imm, 0: R[rt]
//   imm_zext     in   1       1: zero-extend imm, 0: sign-extend imm
//   alu_ctrl_in  in   4       ALU opcode, passed through undecoded
//   wb_en        in   1       register write enable
//   wb_addr      in   5       register write index
//   wb_data      in   DATA_W  register write data
//   out_valid    out  1       output register holds a valid operation
//   out_ready    in   1       ALU consumes the operation this cycle
//   input1       out  DATA_W  registered operand A
//   input2       out  DATA_W  registered operand B
//   ALUControl   out  4       registered ALU opcode
//
// Parameters
//   DATA_W  operand / register width (at least 16)
//   NREGS   register count; the address width is fixed at 5 bits, so this
//           must be 32
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [15:0]       imm,
    input  logic              use_imm,
    input  logic              imm_zext,
    input  logic [3:0]        alu_ctrl_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [3:0]        ALUControl
);

    // Widen the 16-bit immediate to operand width.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm_f,
                                                  input logic        zext_f);
        if (zext_f)
            return {{(DATA_W-16){1'b0}}, imm_f};
        else
            return {{(DATA_W-16){imm_f[15]}}, imm_f};
    endfunction

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] opb_val;
    logic              wb_hit;
    logic              accept;

    logic              vld_p1_q,  vld_p1_d;
    logic [DATA_W-1:0] a_p1_q,    a_p1_d;
    logic [DATA_W-1:0] b_p1_q,    b_p1_d;
    logic [3:0]        ctrl_p1_q, ctrl_p1_d;

    // A write to R0 is dropped, so R0 stays zero.
    assign wb_hit = wb_en && (wb_addr != 5'd0);

    // Register-file write port.
    always_comb begin
        regs_d = regs_q;
        if (wb_hit)
            regs_d[wb_addr] = wb_data;
        regs_d[0] = '0;
    end

    // Combinational read ports, with optional write-through from write-back.
    always_comb begin
        rs_val = (rs_addr == 5'd0) ? '0 : regs_q[rs_addr];
        rt_val = (rt_addr == 5'd0) ? '0 : regs_q[rt_addr];
`ifdef ALU_OPERAND_BYPASS_EN
        if (wb_hit && (wb_addr == rs_addr))
            rs_val = wb_data;
        if (wb_hit && (wb_addr == rt_addr))
            rt_val = wb_data;
`endif
        opb_val = use_imm ? ext_imm(imm, imm_zext) : rt_val;
    end

    // One-deep output buffer. It can take new data when it is empty, or when
    // its current contents are being consumed in the same cycle.
    assign in_ready = !vld_p1_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_p1_d  = accept || (vld_p1_q && !out_ready);
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        ctrl_p1_d = ctrl_p1_q;
        if (accept) begin
            a_p1_d    = rs_val;
            b_p1_d    = opb_val;
            ctrl_p1_d = alu_ctrl_in;
        end
    end

    // Stage p0 -> p1: register file state and the operand register for the ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            vld_p1_q  <= 1'b0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            ctrl_p1_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= regs_d[i];
            vld_p1_q  <= vld_p1_d;
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
            ctrl_p1_q <= ctrl_p1_d;
        end
    end

    assign out_valid  = vld_p1_q;
    assign input1     = a_p1_q;
    assign input2     = b_p1_q;
    assign ALUControl = ctrl_p1_q;

endmodule
